// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator (PRGA) and decryptor: walks the shuffled S memory, XORs with ciphertext ROM, writes plaintext RAM.
// Optional build macro RC4_ASCII_CHECK_EN rejects non-lowercase/space plaintext bytes and stops in FAIL.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [7:0] s_addr,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_q,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_wren,
  output logic       done,
  output logic       fail
);

  typedef enum logic [3:0] {
    IDLE, INC_I, READ_SI, WAIT_SI, CALC_J, READ_SJ, WAIT_SJ,
    WR_SI, WR_SJ, READ_F, WAIT_F, WR_DEC, NEXT, DONE
`ifdef RC4_ASCII_CHECK_EN
    , FAIL
`endif
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t     state_reg, state_next;
  logic [7:0] i_reg, i_next;
  logic [7:0] j_reg, j_next;
  logic [7:0] k_reg, k_next;
  logic [7:0] si_reg, si_next;
  logic [7:0] sj_reg, sj_next;
  logic [7:0] f_reg, f_next;
  logic [7:0] sum_ij;
  logic [7:0] plain;

  assign sum_ij = si_reg + sj_reg;
  assign plain  = f_reg ^ rom_q;

`ifdef RC4_ASCII_CHECK_EN
  function automatic logic is_allowed(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      i_reg     <= 8'd0;
      j_reg     <= 8'd0;
      k_reg     <= 8'd0;
      si_reg    <= 8'd0;
      sj_reg    <= 8'd0;
      f_reg     <= 8'd0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      si_reg    <= si_next;
      sj_reg    <= sj_next;
      f_reg     <= f_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    f_next     = f_reg;
    s_addr     = 8'd0;
    s_data     = 8'd0;
    s_wren     = 1'b0;
    rom_addr   = 8'd0;
    ram_addr   = 8'd0;
    ram_data   = 8'd0;
    ram_wren   = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;

    case (state_reg)
      IDLE:    if (start) state_next = INC_I;
      INC_I: begin
        i_next     = i_reg + 8'd1;
        state_next = READ_SI;
      end
      READ_SI: begin
        s_addr     = i_reg;
        state_next = WAIT_SI;
      end
      WAIT_SI: begin
        s_addr     = i_reg;
        si_next    = s_q;
        state_next = CALC_J;
      end
      CALC_J: begin
        j_next     = j_reg + si_reg;
        state_next = READ_SJ;
      end
      READ_SJ: begin
        s_addr     = j_reg;
        state_next = WAIT_SJ;
      end
      WAIT_SJ: begin
        s_addr     = j_reg;
        sj_next    = s_q;
        state_next = WR_SI;
      end
      // Swap uses the pre-swap copies; i==j writes the same value twice.
      WR_SI: begin
        s_addr     = i_reg;
        s_data     = sj_reg;
        s_wren     = 1'b1;
        state_next = WR_SJ;
      end
      WR_SJ: begin
        s_addr     = j_reg;
        s_data     = si_reg;
        s_wren     = 1'b1;
        state_next = READ_F;
      end
      READ_F: begin
        s_addr     = sum_ij;
        rom_addr   = k_reg;
        state_next = WAIT_F;
      end
      WAIT_F: begin
        s_addr     = sum_ij;
        rom_addr   = k_reg;
        f_next     = s_q;
        state_next = WR_DEC;
      end
      WR_DEC: begin
        ram_addr   = k_reg;
        ram_data   = plain;
        ram_wren   = 1'b1;
        state_next = NEXT;
`ifdef RC4_ASCII_CHECK_EN
        if (!is_allowed(plain)) begin
          ram_wren   = 1'b0;
          state_next = FAIL;
        end
`endif
      end
      NEXT: begin
        if (k_reg == LAST_K) begin
          state_next = DONE;
        end else begin
          k_next     = k_reg + 8'd1;
          state_next = INC_I;
        end
      end
      DONE:    done = 1'b1;
`ifdef RC4_ASCII_CHECK_EN
      FAIL: begin
        done = 1'b1;
        fail = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Dropping start aborts from any state; the current cycle's strobes still complete.
    if (!start) begin
      state_next = IDLE;
      i_next     = 8'd0;
      j_next     = 8'd0;
      k_next     = 8'd0;
    end
  end

endmodule
